gdo_neuron_sequencer: RTL and testbench
=======================================

// Module: gdo_neuron_sequencer
// PURPOSE
//   Sequences gdo package operators to evaluate one neuron: y = act(sum_i(x_i*w_i) + bias).
//   Accepts a job (length, activation, bias), streams N input/weight pairs over valid/ready,
//   accumulates, applies the activation, and returns the result over valid/ready.
//   Sits between the layer scheduler and the combinational gdo_* operators.
//   Owns the single shared multiplier and activation path, one operation per cycle.
// PARAMETERS
//   DW      17  data width, signed fixed point, gdo_one = 2**8 (Q8.8 plus sign)
//   AW      24  internal accumulator width, signed, AW > DW
//   MAX_N   255 maximum pairs per job; job_len width = $clog2(MAX_N+1)
// PORTS
//   clk        in   1    clock
//   rst        in   1    synchronous, active-high reset
//   job_valid  in   1    job descriptor valid
//   job_ready  out  1    sequencer idle and able to accept a job
//   job_len    in   8    number of pairs N (0 legal)
//   job_act    in   2    0=identity 1=gdo_sigmoid 2=gdo_tanh 3=gdo_binary
//   job_bias   in   DW   bias, signed Q8.8
//   in_valid   in   1    pair valid
//   in_ready   out  1    sequencer accepting pairs
//   in_x       in   DW   input operand, signed Q8.8
//   in_w       in   DW   weight operand, signed Q8.8
//   out_valid  out  1    result valid
//   out_ready  in   1    consumer accepts result
//   out_data   out  DW   activated result, signed Q8.8
//   busy       out  1    high in any state except IDLE
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, acc=0, count=0; job_ready=1, in_ready=0,
//     out_valid=0, out_data=0, busy=0. Reset mid-job abandons the job; no result is produced.
//   Handshakes: a transfer occurs on a posedge where valid&&ready. valid must hold
//     until accepted. Sequencer ready outputs are registered state decodes (no comb path in->out).
//   FSM:
//     IDLE  : job_ready=1. On job accept: latch len/act/bias, acc<=0, count<=0;
//             -> ACCUM if len!=0, else -> BIAS.
//     ACCUM : in_ready=1. Each accepted pair: acc <= sat_AW(acc + gdo_mult(in_x,in_w)),
//             count++. On accepting pair count==len-1 -> BIAS. One pair per cycle max.
//     BIAS  : acc <= sat_AW(acc + sext(bias)); -> ACT (1 cycle).
//     ACT   : out_data <= act(sat_DW(acc)); out_valid<=1; -> DONE (1 cycle).
//     DONE  : hold out_data/out_valid until out_ready; on transfer out_valid<=0 -> IDLE.
//   Latency: last pair accept -> out_valid = 2 cycles; job accept with len=0 -> 2 cycles.
//   Throughput: a new job is accepted no earlier than the cycle after the output transfer.
//   Arithmetic: gdo_mult result taken as DW-bit Q8.8 and sign-extended to AW.
//     sat_AW/sat_DW clamp to the signed range of the target width, never wrap.
//     sat_DW range: [-65536, 65535].
//   Boundaries: in_valid in IDLE/BIAS/ACT/DONE ignored (in_ready=0). job_valid outside
//     IDLE ignored. out_ready while out_valid=0 has no effect. len=MAX_N supported.
// STRUCTURE
//   Package gdo (shared): add typedef gdo_data_t (logic signed [16:0]), enum gdo_act_e
//     {GDO_ACT_ID, GDO_ACT_SIG, GDO_ACT_TANH, GDO_ACT_BIN}, and the functions
//     gdo_sat(acc) and gdo_apply_act(gdo_act_e, gdo_data_t) wrapping the existing gdo_* ops.
//   Local enum for FSM states.
//   One sub-module: gdo_mac_unit. Registered acc, inputs clr/en/addend, saturating add.
//     Shared by ACCUM and BIAS via a 2:1 addend mux.
// TESTING
//   1 Identity: len=2, x=(256,512), w=(256,256), bias=0, act=0 -> out_data=768,
//     out_valid 2 cycles after 2nd pair.
//   2 Bias/negative: len=1, x=-256, w=512, bias=128, act=0 -> out_data=-384.
//   3 len=0, bias=256, act=3 (binary) -> out_data=gdo_binary(256), 2 cycles after job accept.
//   4 Saturation: len=4, x=w=32767 each, act=0 -> out_data=65535 (clamped, no wrap).
//   5 Backpressure: hold out_ready=0 for 10 cycles -> out_data stable, job_ready=0 throughout.
//     Random in_valid gaps -> identical result to test 1.
//   6 Reset mid-ACCUM after 1 of 3 pairs -> next cycle IDLE, all outputs at reset values.
//     Next job computes from acc=0.

Source files
------------

// File: rtl/gdo_pkg.sv
// Shared gdo fixed-point types and operators (signed Q8.8, 17-bit data, 24-bit accumulator).
package gdo_pkg;

  localparam int GDO_DW   = 17;
  localparam int GDO_AW   = 24;
  localparam int GDO_FRAC = 8;

  typedef logic signed [GDO_DW-1:0] gdo_data_t;
  typedef logic signed [GDO_AW-1:0] gdo_acc_t;

  typedef enum logic [1:0] {
    GDO_ACT_ID   = 2'd0,
    GDO_ACT_SIG  = 2'd1,
    GDO_ACT_TANH = 2'd2,
    GDO_ACT_BIN  = 2'd3
  } gdo_act_e;

  localparam gdo_data_t GDO_ONE     = 17'sd256;
  localparam gdo_data_t GDO_NEG_ONE = -17'sd256;
  localparam gdo_data_t GDO_DMAX    = gdo_data_t'({1'b0, {(GDO_DW-1){1'b1}}});
  localparam gdo_data_t GDO_DMIN    = gdo_data_t'({1'b1, {(GDO_DW-1){1'b0}}});

  // Sign-extend a data word into accumulator width.
  function automatic gdo_acc_t gdo_sext(gdo_data_t d);
    return gdo_acc_t'({{(GDO_AW-GDO_DW){d[GDO_DW-1]}}, d});
  endfunction

  // Q8.8 multiply; the product is floored to Q8.8 and clamped to the data range.
  function automatic gdo_data_t gdo_mult(gdo_data_t a, gdo_data_t b);
    logic signed [2*GDO_DW-1:0] p;
    logic [GDO_DW-GDO_FRAC:0]   hi;
    p  = $signed({{GDO_DW{a[GDO_DW-1]}}, a}) * $signed({{GDO_DW{b[GDO_DW-1]}}, b});
    hi = p[2*GDO_DW-1:GDO_DW+GDO_FRAC-1];
    if (&hi || ~|hi) return gdo_data_t'(p[GDO_DW+GDO_FRAC-1:GDO_FRAC]);
    else if (p[2*GDO_DW-1]) return GDO_DMIN;
    else return GDO_DMAX;
  endfunction

  // Clamp an accumulator value into the data range.
  function automatic gdo_data_t gdo_sat(gdo_acc_t acc);
    logic [GDO_AW-GDO_DW:0] hi;
    hi = acc[GDO_AW-1:GDO_DW-1];
    if (&hi || ~|hi) return gdo_data_t'(acc[GDO_DW-1:0]);
    else if (acc[GDO_AW-1]) return GDO_DMIN;
    else return GDO_DMAX;
  endfunction

  // Hard sigmoid: x/4 + 0.5, clamped to [0, 1].
  function automatic gdo_data_t gdo_sigmoid(gdo_data_t x);
    gdo_data_t t;
    t = (x >>> 2) + 17'sd128;
    if (t[GDO_DW-1]) return '0;
    else if (t > GDO_ONE) return GDO_ONE;
    else return t;
  endfunction

  // Hard tanh: x clamped to [-1, 1].
  function automatic gdo_data_t gdo_tanh(gdo_data_t x);
    if (x > GDO_ONE) return GDO_ONE;
    else if (x < GDO_NEG_ONE) return GDO_NEG_ONE;
    else return x;
  endfunction

  // Step: 1.0 for x >= 0, else 0.
  function automatic gdo_data_t gdo_binary(gdo_data_t x);
    return x[GDO_DW-1] ? '0 : GDO_ONE;
  endfunction

  function automatic gdo_data_t gdo_apply_act(gdo_act_e act, gdo_data_t x);
    case (act)
      GDO_ACT_SIG:  return gdo_sigmoid(x);
      GDO_ACT_TANH: return gdo_tanh(x);
      GDO_ACT_BIN:  return gdo_binary(x);
      default:      return x;
    endcase
  endfunction

endpackage

// File: rtl/gdo_neuron_sequencer_mac.sv
// Registered saturating accumulator shared by the product and bias phases.
module gdo_mac_unit
  import gdo_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [GDO_AW-1:0] addend,
  output logic signed [GDO_AW-1:0] acc
);

  localparam gdo_acc_t ACC_MAX = gdo_acc_t'({1'b0, {(GDO_AW-1){1'b1}}});
  localparam gdo_acc_t ACC_MIN = gdo_acc_t'({1'b1, {(GDO_AW-1){1'b0}}});

  gdo_acc_t        acc_q, acc_d;
  logic [GDO_AW:0] sum;

  // Next accumulator: clear wins over add; add clamps instead of wrapping.
  always_comb begin
    sum   = {acc_q[GDO_AW-1], acc_q} + {addend[GDO_AW-1], addend};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      if (sum[GDO_AW] != sum[GDO_AW-1]) acc_d = sum[GDO_AW] ? ACC_MIN : ACC_MAX;
      else acc_d = gdo_acc_t'(sum[GDO_AW-1:0]);
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/gdo_neuron_sequencer.sv
// Single-neuron sequencer: y = act(sum(x*w) + bias), one MAC operation per cycle.
//
// state | meaning
// IDLE  | waiting for a job descriptor (job_ready)
// ACCUM | accepting x/w pairs, one product accumulated per accepted pair
// BIAS  | adding the latched bias to the accumulator
// ACT   | saturating to data width, applying activation, raising out_valid
// DONE  | holding the result until the consumer takes it
//
// The datapath is built on the gdo_pkg widths; DW/AW must stay at their defaults.
module gdo_neuron_sequencer
  import gdo_pkg::*;
#(
  parameter int DW    = GDO_DW,
  parameter int AW    = GDO_AW,
  parameter int MAX_N = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [$clog2(MAX_N+1)-1:0]      job_len,
  input  logic [1:0]                      job_act,
  input  logic signed [DW-1:0]            job_bias,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [DW-1:0]            in_x,
  input  logic signed [DW-1:0]            in_w,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [DW-1:0]            out_data,
  output logic                            busy
);

  localparam int LW = $clog2(MAX_N + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_BIAS  = 3'd2,
    S_ACT   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   count_q, count_d;
  gdo_act_e        act_q, act_d;
  gdo_data_t       bias_q, bias_d;
  logic            out_valid_q, out_valid_d;
  gdo_data_t       out_data_q, out_data_d;

  logic            job_fire, in_fire, out_fire;
  logic            mac_clr, mac_en;
  logic signed [AW-1:0] mac_addend, acc;

  // Ready/busy are pure decodes of the state register, so no input reaches them.
  assign job_ready = (state_q == S_IDLE);
  assign in_ready  = (state_q == S_ACCUM);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  assign job_fire = job_valid && job_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  assign mac_clr = job_fire;
  assign mac_en  = in_fire || (state_q == S_BIAS);

  // Addend mux: bias during BIAS, otherwise the current pair's product.
  always_comb begin
    mac_addend = (state_q == S_BIAS) ? gdo_sext(bias_q) : gdo_sext(gdo_mult(in_x, in_w));
  end

  gdo_mac_unit u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .addend (mac_addend),
    .acc    (acc)
  );

  // Next-state and job/result register updates.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    act_d       = act_q;
    bias_d      = bias_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (job_fire) begin
          len_d   = job_len;
          act_d   = gdo_act_e'(job_act);
          bias_d  = job_bias;
          count_d = '0;
          state_d = (job_len != '0) ? S_ACCUM : S_BIAS;
        end
      end
      S_ACCUM: begin
        if (in_fire) begin
          count_d = count_q + LW'(1);
          if (count_q == len_q - LW'(1)) state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        state_d = S_ACT;
      end
      S_ACT: begin
        out_data_d  = gdo_apply_act(act_q, gdo_sat(acc));
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and job registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      count_q     <= '0;
      act_q       <= GDO_ACT_ID;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      act_q       <= act_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_gdo_neuron_sequencer.sv
// Bench for gdo_neuron_sequencer: directed vector table, mid-job reset, random jobs vs a model.
module tb_gdo_neuron_sequencer;

  localparam int DW    = 17;
  localparam int AW    = 24;
  localparam int MAX_N = 255;
  localparam int LW    = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 job_valid;
  logic                 job_ready;
  logic [LW-1:0]        job_len;
  logic [1:0]           job_act;
  logic signed [DW-1:0] job_bias;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_x;
  logic signed [DW-1:0] in_w;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 busy;

  gdo_neuron_sequencer #(.DW(DW), .AW(AW), .MAX_N(MAX_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_len   (job_len),
    .job_act   (job_act),
    .job_bias  (job_bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_vec = 0;
  int n_bad = 0;

  int pair_x[256];
  int pair_w[256];

  typedef struct {
    int len;
    int act;
    int bias;
    int x[4];
    int w[4];
    int gap;
    int hold;
    int exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add_vec(input int len, input int act, input int bias,
                         input int x0, input int x1, input int x2, input int x3,
                         input int w0, input int w1, input int w2, input int w3,
                         input int gap, input int hold, input int exp);
    vec_t v;
    v.len = len; v.act = act; v.bias = bias;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.gap = gap; v.hold = hold; v.exp = exp;
    tbl.push_back(v);
  endtask

  function automatic longint clamp(longint v, longint lo, longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference: real-number rules with floor to 1/256 and clamping at each stage.
  function automatic longint model(int len, int act, int bias);
    longint acc, p, d;
    acc = 0;
    for (int i = 0; i < len; i++) begin
      p   = clamp((longint'(pair_x[i]) * longint'(pair_w[i])) >>> 8, -65536, 65535);
      acc = clamp(acc + p, -8388608, 8388607);
    end
    acc = clamp(acc + bias, -8388608, 8388607);
    d   = clamp(acc, -65536, 65535);
    case (act)
      1:       return clamp((d >>> 2) + 128, 0, 256);
      2:       return clamp(d, -256, 256);
      3:       return (d >= 0) ? 256 : 0;
      default: return d;
    endcase
  endfunction

  // Runs one job end to end; reports result and latency (cycles from last accept to out_valid).
  task automatic do_job(input int len, input int act, input int bias, input int gap,
                        input int hold, output longint res, output int lat);
    int  i, guard, ref_idx;
    bit  fire;
    res = 0;
    lat = -1;
    @(negedge clk);
    out_ready = (hold == 0);
    job_valid = 1'b1;
    job_len   = LW'(len);
    job_act   = 2'(act);
    job_bias  = DW'(bias);
    guard = 0;
    fire  = 1'b0;
    while (!fire && guard < 50) begin
      fire = job_ready;
      @(negedge clk);
      guard++;
    end
    job_valid = 1'b0;
    if (!fire) begin
      check("job_accept_timeout", 0, 1);
      return;
    end
    ref_idx = cyc_cnt;
    i = 0;
    guard = 0;
    while (i < len && guard < 20 * len + 100) begin
      if (int'($urandom_range(99)) < gap) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_x = DW'(pair_x[i]);
        in_w = DW'(pair_w[i]);
      end
      fire = in_valid && in_ready;
      @(negedge clk);
      guard++;
      if (fire) begin
        i++;
        ref_idx = cyc_cnt;
      end
    end
    in_valid = 1'b0;
    if (i < len) begin
      check("pair_accept_timeout", i, len);
      return;
    end
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      out_ready = 1'b0;
      return;
    end
    lat = cyc_cnt - ref_idx;
    res = out_data;
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      in_x      = DW'($urandom);
      in_w      = DW'($urandom);
      job_valid = 1'b1;
      job_len   = 8'd5;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_data", out_data, res);
      check("hold_job_ready", job_ready, 0);
    end
    in_valid  = 1'b0;
    job_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("job_ready_after", job_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint res, exp;
    int     lat, len, act, bias;

    rst = 1'b1; job_valid = 1'b0; job_len = '0; job_act = '0; job_bias = '0;
    in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_job_ready", job_ready, 1);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;

    //      len act bias   x0     x1     x2     x3     w0      w1      w2      w3   gap hold exp
    add_vec(2,  0,  0,     256,   512,   0,     0,     256,    256,    0,      0,    0,  0,   768);
    add_vec(1,  0,  128,   -256,  0,     0,     0,     512,    0,      0,      0,    0,  0,   -384);
    add_vec(0,  3,  256,   0,     0,     0,     0,     0,      0,      0,      0,    0,  0,   256);
    add_vec(4,  0,  0,     32767, 32767, 32767, 32767, 32767,  32767,  32767,  32767,0,  0,   65535);
    add_vec(2,  0,  0,     256,   512,   0,     0,     256,    256,    0,      0,    40, 10,  768);
    add_vec(1,  1,  0,     256,   0,     0,     0,     256,    0,      0,      0,    0,  2,   192);
    add_vec(1,  2,  0,     -1024, 0,     0,     0,     512,    0,      0,      0,    0,  0,   -256);
    add_vec(0,  3,  -5,    0,     0,     0,     0,     0,      0,      0,      0,    0,  1,   0);
    add_vec(4,  0,  0,     32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768,20, 0,  -65536);
    add_vec(0,  1,  2000,  0,     0,     0,     0,     0,      0,      0,      0,    0,  0,   256);

    foreach (tbl[k]) begin
      for (int i = 0; i < 4; i++) begin
        pair_x[i] = tbl[k].x[i];
        pair_w[i] = tbl[k].w[i];
      end
      do_job(tbl[k].len, tbl[k].act, tbl[k].bias, tbl[k].gap, tbl[k].hold, res, lat);
      check($sformatf("vec%0d_data", k), res, tbl[k].exp);
      check($sformatf("vec%0d_latency", k), lat, 2);
    end

    // Reset after one of three pairs: job abandoned, next job starts from a clean accumulator.
    @(negedge clk);
    job_valid = 1'b1; job_len = 8'd3; job_act = 2'd0; job_bias = 17'sd1000;
    @(negedge clk);
    job_valid = 1'b0;
    check("midrst_accum_in_ready", in_ready, 1);
    in_valid = 1'b1; in_x = 17'sd4096; in_w = 17'sd4096;
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_job_ready", job_ready, 1);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    pair_x[0] = 256; pair_x[1] = 512; pair_w[0] = 256; pair_w[1] = 256;
    do_job(2, 0, 0, 0, 0, res, lat);
    check("post_rst_data", res, 768);
    check("post_rst_latency", lat, 2);

    // Longest job, moderate operands.
    for (int i = 0; i < MAX_N; i++) begin
      pair_x[i] = int'($urandom_range(512)) - 256;
      pair_w[i] = int'($urandom_range(512)) - 256;
    end
    exp = model(MAX_N, 0, 77);
    do_job(MAX_N, 0, 77, 30, 1, res, lat);
    check("maxn_data", res, exp);
    check("maxn_latency", lat, 2);

    // Random jobs against the model.
    for (int j = 0; j < 40; j++) begin
      len  = int'($urandom_range(12));
      act  = int'($urandom_range(3));
      bias = int'($urandom_range(131071)) - 65536;
      if (j % 3 == 0) bias = int'($urandom_range(2048)) - 1024;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3) == 0) begin
          pair_x[i] = int'($urandom_range(131071)) - 65536;
          pair_w[i] = int'($urandom_range(131071)) - 65536;
        end else begin
          pair_x[i] = int'($urandom_range(2048)) - 1024;
          pair_w[i] = int'($urandom_range(2048)) - 1024;
        end
      end
      exp = model(len, act, bias);
      do_job(len, act, bias, int'($urandom_range(50)), int'($urandom_range(3)), res, lat);
      check($sformatf("rand%0d_data", j), res, exp);
      check($sformatf("rand%0d_latency", j), lat, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
